// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit driving a single-port synchronous memory
module mem_access_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  // READ occupies MEM_LAT cycles; the counter counts down to zero.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Reserved size, or a half/word not on its natural boundary.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Move the addressed lane down to bit 0 and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    return r;
  endfunction

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state and next-output decode; outputs are registered so they change with the state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          size_d   = req_size;
          we_d     = req_we;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (access_err(req_size, req_addr[1:0])) begin
            // Bad requests never reach the memory; answer on the next cycle.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_we && (req_size == SZ_WORD)) begin
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
            state_d     = S_WRITE;
          end else begin
            // Loads and sub-word stores both start by reading the word.
            mem_addr_d = {req_addr[31:2], 2'b00};
            cnt_d      = LAT_INIT;
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          if (we_q) begin
            mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, off_q);
            mem_we_d    = 1'b1;
            state_d     = S_WRITE;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_extract(mem_rdata, size_q, off_q, signed_q);
            state_d      = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, valid1, valid3;
  logic        we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic        rdy1, rv1, re1, mwe1;
  logic [31:0] rd1, ma1, mwd1, mrd1;
  logic        rdy3, rv3, re3, mwe3;
  logic [31:0] rd3, ma3, mwd3, mrd3;

  mem_access_unit #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(rdy1), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1), .mem_addr(ma1),
    .mem_we(mwe1), .mem_wdata(mwd1), .mem_rdata(mrd1)
  );

  mem_access_unit #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst3), .req_valid(valid3), .req_ready(rdy3), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv3), .resp_err(re3), .resp_rdata(rd3), .mem_addr(ma3),
    .mem_we(mwe3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );

  // Memories: 256 words each, plus a backdoor write port for preloading.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] ref_mem [256];
  logic        bd_we, bd_sel;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] a3_p1, a3_p2;

  always @(posedge clk) begin
    if (bd_we && !bd_sel) mem1[bd_idx] <= bd_data;
    else if (mwe1) mem1[ma1[9:2]] <= mwd1;
    if (bd_we && bd_sel) mem3[bd_idx] <= bd_data;
    else if (mwe3) mem3[ma3[9:2]] <= mwd3;
    a3_p1 <= ma3;
    a3_p2 <= a3_p1;
  end

  // Latency 1: data follows the address in the same cycle. Latency 3: address delayed two cycles.
  assign mrd1 = mem1[ma1[9:2]];
  assign mrd3 = mem3[a3_p2[9:2]];

  bit          sel;
  logic        s_rdy, s_rv, s_re, s_mwe;
  logic [31:0] s_rd, s_ma, s_mwd;
  always_comb begin
    s_rdy = sel ? rdy3 : rdy1;
    s_rv  = sel ? rv3  : rv1;
    s_re  = sel ? re3  : re1;
    s_rd  = sel ? rd3  : rd1;
    s_ma  = sel ? ma3  : ma1;
    s_mwe = sel ? mwe3 : mwe1;
    s_mwd = sel ? mwd3 : mwd1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input bit s, input int idx, input logic [31:0] d);
    bd_sel = s; bd_idx = 8'(idx); bd_data = d; bd_we = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // One request, started at a negedge; returns at the negedge where resp_valid was seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int wecnt, output logic [31:0] waddr, output logic [31:0] wdat,
                        output logic maddr_kept);
    logic [31:0] ma_before;
    ma_before = s_ma;
    we = w; size = sz; sgn = sg; addr = a; wdata = d;
    if (sel) valid3 = 1'b1; else valid1 = 1'b1;
    lat = -1; rdata = 'x; err = 1'bx; wecnt = 0; waddr = 0; wdat = 0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid1 = 1'b0; valid3 = 1'b0;
      if (s_mwe) begin wecnt++; waddr = s_ma; wdat = s_mwd; end
      if (s_rv) begin lat = k; rdata = s_rd; err = s_re; break; end
    end
    maddr_kept = (s_ma == ma_before);
  endtask

  // Reference model: behaviour from the access rules, applied to ref_mem.
  task automatic ref_op(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input int mlat,
                        output logic e_err, output logic [31:0] e_rd, output int e_lat,
                        output int e_we, output logic [31:0] e_wa, output logic [31:0] e_wd);
    int unsigned off, widx, nbytes;
    logic [31:0] word, lane, mask;
    off = a % 4; widx = (a / 4) % 256;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    e_err = (sz == 3) || (a % nbytes != 0);
    e_rd = 0; e_we = 0; e_wa = 0; e_wd = 0;
    word = ref_mem[widx];
    if (e_err) begin
      e_lat = 1;
    end else if (!w) begin
      e_lat = mlat + 1;
      if (nbytes == 4) e_rd = word;
      else begin
        lane = (word >> (8 * off)) % (32'd1 << (8 * nbytes));
        if (sg && lane >= (32'd1 << (8 * nbytes - 1))) lane = lane - (32'd1 << (8 * nbytes));
        e_rd = lane;
      end
    end else begin
      e_lat = (nbytes == 4) ? 2 : mlat + 2;
      mask = (nbytes == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * nbytes)) - 1) << (8 * off));
      e_we = 1;
      e_wa = a - off;
      e_wd = (word & ~mask) | ((d << (8 * off)) & mask);
      ref_mem[widx] = e_wd;
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_we;
    logic [31:0] e_wa;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] d, input logic e_err,
                              input logic [31:0] e_rd, input int e_lat, input int e_we,
                              input logic [31:0] e_wa, input logic [31:0] e_wd);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.d = d; v.e_err = e_err; v.e_rd = e_rd;
    v.e_lat = e_lat; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    int lat, wecnt, e_lat, e_we, nbad, seen_we, seen_rv;
    logic [31:0] rdata, waddr, wdat, e_rd, e_wa, e_wd, rw;
    logic err, kept, e_err;
    logic [1:0] rsz;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int b2b_cyc [3];
    int idx;

    // Directed vectors for the latency-1 unit, starting from mem[0x100]=0x8899AABB.
    vq.push_back(mk(0, 2'b10, 0, 32'h100, 0,            0, 32'h8899AABB, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b00, 1, 32'h101, 0,            0, 32'hFFFFFFAA, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b00, 0, 32'h101, 0,            0, 32'h000000AA, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 1, 32'h102, 0,            0, 32'hFFFF8899, 2, 0, 0, 0));
    vq.push_back(mk(1, 2'b01, 0, 32'h102, 32'h00001234, 0, 32'h0,        3, 1, 32'h100, 32'h1234AABB));
    vq.push_back(mk(0, 2'b10, 0, 32'h100, 0,            0, 32'h1234AABB, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 0, 32'h103, 0,            1, 32'h0,        1, 0, 0, 0));
    vq.push_back(mk(1, 2'b10, 0, 32'h101, 32'hCAFE0000, 1, 32'h0,        1, 0, 0, 0));
    vq.push_back(mk(0, 2'b11, 0, 32'h100, 0,            1, 32'h0,        1, 0, 0, 0));
    vq.push_back(mk(1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'h104, 32'hDEADBEEF));
    vq.push_back(mk(1, 2'b00, 0, 32'h107, 32'hFFFFFF55, 0, 32'h0,        3, 1, 32'h104, 32'h55ADBEEF));
    vq.push_back(mk(0, 2'b00, 1, 32'h107, 0,            0, 32'h00000055, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 0, 32'h104, 0,            0, 32'h0000BEEF, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 1, 32'h104, 0,            0, 32'hFFFFBEEF, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b00, 1, 32'h106, 0,            0, 32'hFFFFFFAD, 2, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 1, 32'h104, 0,            0, 32'h55ADBEEF, 2, 0, 0, 0));

    rst1 = 1; rst3 = 1; valid1 = 0; valid3 = 0; we = 0; sgn = 0; size = 0; addr = 0; wdata = 0;
    bd_we = 0; bd_sel = 0; bd_idx = 0; bd_data = 0; sel = 0;
    repeat (2) @(negedge clk);

    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_resp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_resp_err", {31'd0, re1}, 32'd0);
    chk("rst_resp_rdata", rd1, 32'd0);
    chk("rst_mem_addr", ma1, 32'd0);
    chk("rst_mem_we", {31'd0, mwe1}, 32'd0);
    chk("rst_mem_wdata", mwd1, 32'd0);
    chk("rst3_ready", {31'd0, rdy3}, 32'd1);
    rst1 = 0; rst3 = 0;

    poke(0, 32'h100 / 4, 32'h8899AABB);
    poke(0, 32'hFC / 4, 32'h11223344);
    poke(1, 32'h100 / 4, 32'h8899AABB);
    @(negedge clk);

    foreach (vq[i]) begin
      chk($sformatf("vec%0d_ready", i), {31'd0, s_rdy}, 32'd1);
      do_req(vq[i].w, vq[i].sz, vq[i].sg, vq[i].a, vq[i].d, lat, rdata, err, wecnt, waddr, wdat, kept);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vq[i].e_lat));
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vq[i].e_err});
      chk($sformatf("vec%0d_rdata", i), rdata, vq[i].e_rd);
      chk($sformatf("vec%0d_we_cycles", i), 32'(wecnt), 32'(vq[i].e_we));
      if (vq[i].e_we == 1) begin
        chk($sformatf("vec%0d_mem_addr", i), waddr, vq[i].e_wa);
        chk($sformatf("vec%0d_mem_wdata", i), wdat, vq[i].e_wd);
      end
      if (vq[i].e_err) chk($sformatf("vec%0d_addr_kept", i), {31'd0, kept}, 32'd1);
    end

    // Back-to-back byte loads with req_valid held high throughout.
    b2b_addr[0] = 32'd253; b2b_addr[1] = 32'd254; b2b_addr[2] = 32'd255;
    b2b_exp[0] = 32'h33; b2b_exp[1] = 32'h22; b2b_exp[2] = 32'h11;
    b2b_cyc[0] = -1; b2b_cyc[1] = -1; b2b_cyc[2] = -1;
    we = 0; size = 2'b00; sgn = 0; addr = b2b_addr[0]; valid1 = 1;
    idx = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && idx < 3; cyc++) begin
      @(negedge clk);
      if (rv1) begin
        chk($sformatf("b2b%0d_rdata", idx), rd1, b2b_exp[idx]);
        b2b_cyc[idx] = cyc;
        idx++;
        if (idx < 3) addr = b2b_addr[idx]; else valid1 = 0;
      end
    end
    valid1 = 0;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d_cycle", i), 32'(b2b_cyc[i]), 32'(2 * (i + 1)));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 256; i++) begin
      rw = $urandom;
      poke(0, i, rw);
      ref_mem[i] = rw;
    end
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      logic rw_we, rsg;
      logic [31:0] ra, rdat;
      rw_we = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      rsg = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 1023));
      rdat = $urandom;
      ref_op(rw_we, rsz, rsg, ra, rdat, 1, e_err, e_rd, e_lat, e_we, e_wa, e_wd);
      do_req(rw_we, rsz, rsg, ra, rdat, lat, rdata, err, wecnt, waddr, wdat, kept);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, e_err});
      chk($sformatf("rnd%0d_rdata", i), rdata, e_rd);
      chk($sformatf("rnd%0d_we_cycles", i), 32'(wecnt), 32'(e_we));
      if (e_we == 1) begin
        chk($sformatf("rnd%0d_mem_addr", i), waddr, e_wa);
        chk($sformatf("rnd%0d_mem_wdata", i), wdat, e_wd);
      end
      if (e_err) chk($sformatf("rnd%0d_addr_kept", i), {31'd0, kept}, 32'd1);
    end
    @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem1[i] !== ref_mem[i]) nbad++;
    chk("rnd_mem_contents", 32'(nbad), 32'd0);

    // Latency-3 unit: load, sub-word store, then a store aborted by reset.
    sel = 1;
    do_req(0, 2'b10, 0, 32'h100, 0, lat, rdata, err, wecnt, waddr, wdat, kept);
    chk("lat3_load_lat", 32'(lat), 32'd4);
    chk("lat3_load_rdata", rdata, 32'h8899AABB);
    do_req(1, 2'b00, 0, 32'h101, 32'h00000077, lat, rdata, err, wecnt, waddr, wdat, kept);
    chk("lat3_store_lat", 32'(lat), 32'd5);
    chk("lat3_store_we_cycles", 32'(wecnt), 32'd1);
    chk("lat3_store_wdata", wdat, 32'h889977BB);

    seen_we = 0; seen_rv = 0;
    we = 1; size = 2'b00; sgn = 0; addr = 32'h100; wdata = 32'h000000A5; valid3 = 1;
    @(posedge clk);
    @(negedge clk);
    valid3 = 0;
    if (mwe3) seen_we++;
    if (rv3) seen_rv++;
    @(negedge clk);
    rst3 = 1;
    #1;
    chk("abort_ready_in_reset", {31'd0, rdy3}, 32'd1);
    chk("abort_we_in_reset", {31'd0, mwe3}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_ready_held", {31'd0, rdy3}, 32'd1);
    rst3 = 0;
    repeat (10) begin
      @(negedge clk);
      if (mwe3) seen_we++;
      if (rv3) seen_rv++;
    end
    chk("abort_no_mem_we", 32'(seen_we), 32'd0);
    chk("abort_no_resp", 32'(seen_rv), 32'd0);
    chk("abort_mem_unchanged", mem3[32'h100 / 4], 32'h889977BB);
    chk("abort_ready_after", {31'd0, rdy3}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
